fft_32_point: RTL and testbench
===============================

# fft_32_point

Combinational-free, fully pipelined 32-point radix-2 decimation-in-time FFT on real-valued signed fixed-point samples. It accepts one complete 32-sample frame per clock and produces 32 complex bins per clock after a fixed latency. It sits in the signal-processing datapath between a sample-capture buffer and downstream spectral logic. There is no handshake: every clock edge is a new frame.

## Interface
- No parameters. Widths and format are fixed: data Q16.16 signed two's complement; twiddles Q1.14 signed 16-bit.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- in0_r .. in31_r  input  32 each  real time-domain samples x[0]..x[31], Q16.16. The imaginary part is implicitly 0.
- out0_r .. out31_r  output  32 each  real part of bin X[0]..X[31], Q16.16.
- out0_i .. out31_i  output  32 each  imaginary part of bin X[0]..X[31], Q16.16.

## Operation
- Computes X[k] = Σ x[n]·W^(nk), with W = exp(−j2π/32) and no normalization. X[0] is the plain sum.
- **Stage 0 (input register):**
  - Registers all 32 inputs in bit-reversed order: slot i holds x[bitrev5(i)].
  - Real part is the sample; imaginary part is 0.
- **Stages 1..5 (butterflies):** 16 butterflies per stage, each stage registered.
  - Span h = 2^(s−1). Elements j and j+h pair within groups of size 2h.
  - Twiddle index k = (j mod h)·(16/h).
  - t = W^k·b; a' = a + t; b' = a − t.
- **Twiddle ROM:** 16 entries, k = 0..15.
  - wr = round(16384·cos(2πk/32)); wi = round(−16384·sin(2πk/32)).
  - k=0 is (16384, 0). k=8 is (0, −16384). k=4 is (11585, −11585).
- **Complex multiply:**
  - re = (br·wr − bi·wi) >>> 14; im = (br·wi + bi·wr) >>> 14.
  - 32×16 signed products; accumulate in at least 49 bits; arithmetic shift (truncation toward −∞).
  - Keep the low 32 bits of the result.
- **Add/subtract:** 32-bit two's complement, wraps on overflow with no saturation.
  - Total gain up to 32×, so callers must keep |x| < 2^10 (1024.0) to avoid wrap.
- **Output ordering:** final-stage slot k is bin X[k] in natural order. Outputs are driven directly from the stage-5 registers.

## Timing
- **Latency:**
  - Inputs sampled at rising edge N.
  - Corresponding bins appear on the outputs immediately after edge N+5 (6 register stages).
  - Outputs are stable until edge N+6.
- **Throughput:** one frame per cycle. Frames issued on consecutive edges emerge on consecutive cycles, uncorrupted.
- **Reset:**
  - Any rising edge with rst=0 clears every pipeline register, so all 64 outputs are 0x00000000 after that edge.
  - Reset asserted mid-stream discards all in-flight frames.
- **After reset release:**
  - Sampling resumes at the first edge with rst=1. Call that edge R.
  - Outputs reflect the cleared pipeline (zeros, since a zero frame transforms to zeros) until after edge R+5.
  - The first valid bins for the frame sampled at R appear after edge R+5.
- **Unknown inputs:** X/undefined inputs during reset have no effect on outputs.

## Test plan
- **Impulse:** in0_r=0x00010000, all others 0, rst=1 → after 6 edges every outN_r=0x00010000 and every outN_i=0x00000000.
- **DC:** all inputs 0x00010000 → out0_r=0x00200000, out0_i=0; all other bins exactly 0.
- **Nyquist:** inputs alternate +1.0 (0x00010000) / −1.0 (0xFFFF0000), starting +1.0 at in0 → out16_r=0x00200000; all other bins 0.
- **Delayed impulse:** in1_r=0x00010000, others 0 → out0 = (0x00010000, 0); out8 = (0, 0xFFFF0000); out16 = (0xFFFF0000, 0); out24 = (0, 0x00010000); out4_r = out4_i magnitude 0x0000B504 ±1 LSB, with out4_i negative.
- **Cosine bin 1:** in_n = round(65536·cos(2πn/32)) → out1_r and out31_r ≈ 0x00100000 (±0x40); out1_i, out31_i and all other bins ≈ 0 (±0x40).
- **Reset and pipelining:**
  - Stream the DC and impulse frames on consecutive edges; they emerge on consecutive cycles with the results above.
  - Pull rst low for one edge mid-stream → all outputs 0 after that edge.
  - Outputs stay 0 until 6 edges after release, then match the frame applied at release.

Source files
------------

// File: rtl/fft_32_point.sv
// rtl/fft_32_point.sv - fully pipelined 32-point radix-2 DIT FFT, real Q16.16 in, complex Q16.16 out
// One frame per clock; six register ranks: bit-reversed capture, then five butterfly stages.
module fft_32_point (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in0_r,  in1_r,  in2_r,  in3_r,  in4_r,  in5_r,  in6_r,  in7_r,
                      in8_r,  in9_r,  in10_r, in11_r, in12_r, in13_r, in14_r, in15_r,
                      in16_r, in17_r, in18_r, in19_r, in20_r, in21_r, in22_r, in23_r,
                      in24_r, in25_r, in26_r, in27_r, in28_r, in29_r, in30_r, in31_r,
  output logic [31:0] out0_r,  out1_r,  out2_r,  out3_r,  out4_r,  out5_r,  out6_r,  out7_r,
                      out8_r,  out9_r,  out10_r, out11_r, out12_r, out13_r, out14_r, out15_r,
                      out16_r, out17_r, out18_r, out19_r, out20_r, out21_r, out22_r, out23_r,
                      out24_r, out25_r, out26_r, out27_r, out28_r, out29_r, out30_r, out31_r,
  output logic [31:0] out0_i,  out1_i,  out2_i,  out3_i,  out4_i,  out5_i,  out6_i,  out7_i,
                      out8_i,  out9_i,  out10_i, out11_i, out12_i, out13_i, out14_i, out15_i,
                      out16_i, out17_i, out18_i, out19_i, out20_i, out21_i, out22_i, out23_i,
                      out24_i, out25_i, out26_i, out27_i, out28_i, out29_i, out30_i, out31_i
);

  // W^k = exp(-j*2*pi*k/32) in Q1.14, k = 0..15
  localparam logic signed [15:0] TW_RE [16] = '{
    16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
    16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
    16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
   -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069
  };
  localparam logic signed [15:0] TW_IM [16] = '{
    16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
   -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
   -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623,
   -16'sd11585, -16'sd9102,  -16'sd6270,  -16'sd3196
  };

  logic signed [31:0] x_in   [32];
  logic signed [31:0] st_r_d [6][32];
  logic signed [31:0] st_i_d [6][32];
  logic signed [31:0] st_r_q [6][32];
  logic signed [31:0] st_i_q [6][32];

  assign x_in = '{in0_r,  in1_r,  in2_r,  in3_r,  in4_r,  in5_r,  in6_r,  in7_r,
                  in8_r,  in9_r,  in10_r, in11_r, in12_r, in13_r, in14_r, in15_r,
                  in16_r, in17_r, in18_r, in19_r, in20_r, in21_r, in22_r, in23_r,
                  in24_r, in25_r, in26_r, in27_r, in28_r, in29_r, in30_r, in31_r};

  for (genvar i = 0; i < 32; i++) begin : g_in
    localparam int REV = ((i & 1) << 4) | ((i & 2) << 2) | (i & 4) | ((i & 8) >> 2) | ((i & 16) >> 4);
    assign st_r_d[0][i] = x_in[REV];
    assign st_i_d[0][i] = '0;
  end

  for (genvar s = 1; s <= 5; s++) begin : g_stage
    localparam int H = 1 << (s - 1);
    for (genvar b = 0; b < 16; b++) begin : g_bf
      localparam int POS = b % H;
      localparam int J   = (b / H) * (2 * H) + POS;
      localparam int K   = POS * (16 / H);
      localparam logic signed [48:0] WR = 49'(TW_RE[K]);
      localparam logic signed [48:0] WI = 49'(TW_IM[K]);

      logic signed [31:0] ar, ai, tr, ti;
      logic signed [48:0] br_x, bi_x, pr, pi;

      assign ar   = st_r_q[s-1][J];
      assign ai   = st_i_q[s-1][J];
      assign br_x = 49'(st_r_q[s-1][J+H]);
      assign bi_x = 49'(st_i_q[s-1][J+H]);

      // Full-precision product, floor-shift back to Q16.16, keep the low 32 bits
      assign pr = br_x * WR - bi_x * WI;
      assign pi = br_x * WI + bi_x * WR;
      assign tr = 32'(pr >>> 14);
      assign ti = 32'(pi >>> 14);

      assign st_r_d[s][J]   = ar + tr;
      assign st_i_d[s][J]   = ai + ti;
      assign st_r_d[s][J+H] = ar - tr;
      assign st_i_d[s][J+H] = ai - ti;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int si = 0; si < 6; si++) begin
        for (int ni = 0; ni < 32; ni++) begin
          st_r_q[si][ni] <= '0;
          st_i_q[si][ni] <= '0;
        end
      end
    end else begin
      st_r_q <= st_r_d;
      st_i_q <= st_i_d;
    end
  end

  assign out0_r  = st_r_q[5][0];   assign out0_i  = st_i_q[5][0];
  assign out1_r  = st_r_q[5][1];   assign out1_i  = st_i_q[5][1];
  assign out2_r  = st_r_q[5][2];   assign out2_i  = st_i_q[5][2];
  assign out3_r  = st_r_q[5][3];   assign out3_i  = st_i_q[5][3];
  assign out4_r  = st_r_q[5][4];   assign out4_i  = st_i_q[5][4];
  assign out5_r  = st_r_q[5][5];   assign out5_i  = st_i_q[5][5];
  assign out6_r  = st_r_q[5][6];   assign out6_i  = st_i_q[5][6];
  assign out7_r  = st_r_q[5][7];   assign out7_i  = st_i_q[5][7];
  assign out8_r  = st_r_q[5][8];   assign out8_i  = st_i_q[5][8];
  assign out9_r  = st_r_q[5][9];   assign out9_i  = st_i_q[5][9];
  assign out10_r = st_r_q[5][10];  assign out10_i = st_i_q[5][10];
  assign out11_r = st_r_q[5][11];  assign out11_i = st_i_q[5][11];
  assign out12_r = st_r_q[5][12];  assign out12_i = st_i_q[5][12];
  assign out13_r = st_r_q[5][13];  assign out13_i = st_i_q[5][13];
  assign out14_r = st_r_q[5][14];  assign out14_i = st_i_q[5][14];
  assign out15_r = st_r_q[5][15];  assign out15_i = st_i_q[5][15];
  assign out16_r = st_r_q[5][16];  assign out16_i = st_i_q[5][16];
  assign out17_r = st_r_q[5][17];  assign out17_i = st_i_q[5][17];
  assign out18_r = st_r_q[5][18];  assign out18_i = st_i_q[5][18];
  assign out19_r = st_r_q[5][19];  assign out19_i = st_i_q[5][19];
  assign out20_r = st_r_q[5][20];  assign out20_i = st_i_q[5][20];
  assign out21_r = st_r_q[5][21];  assign out21_i = st_i_q[5][21];
  assign out22_r = st_r_q[5][22];  assign out22_i = st_i_q[5][22];
  assign out23_r = st_r_q[5][23];  assign out23_i = st_i_q[5][23];
  assign out24_r = st_r_q[5][24];  assign out24_i = st_i_q[5][24];
  assign out25_r = st_r_q[5][25];  assign out25_i = st_i_q[5][25];
  assign out26_r = st_r_q[5][26];  assign out26_i = st_i_q[5][26];
  assign out27_r = st_r_q[5][27];  assign out27_i = st_i_q[5][27];
  assign out28_r = st_r_q[5][28];  assign out28_i = st_i_q[5][28];
  assign out29_r = st_r_q[5][29];  assign out29_i = st_i_q[5][29];
  assign out30_r = st_r_q[5][30];  assign out30_i = st_i_q[5][30];
  assign out31_r = st_r_q[5][31];  assign out31_i = st_i_q[5][31];

endmodule

// File: tb/tb_fft_32_point.sv
// tb/tb_fft_32_point.sv - directed and random frames against a DFT-level reference with a latency scoreboard
module tb_fft_32_point;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cur [32];
  logic [31:0] o_r [32];
  logic [31:0] o_i [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          p_r [6][32];
  int          p_i [6][32];

  always #5 clk = ~clk;

  fft_32_point dut (
    .clk(clk), .rst(rst),
    .in0_r(cur[0]),   .in1_r(cur[1]),   .in2_r(cur[2]),   .in3_r(cur[3]),
    .in4_r(cur[4]),   .in5_r(cur[5]),   .in6_r(cur[6]),   .in7_r(cur[7]),
    .in8_r(cur[8]),   .in9_r(cur[9]),   .in10_r(cur[10]), .in11_r(cur[11]),
    .in12_r(cur[12]), .in13_r(cur[13]), .in14_r(cur[14]), .in15_r(cur[15]),
    .in16_r(cur[16]), .in17_r(cur[17]), .in18_r(cur[18]), .in19_r(cur[19]),
    .in20_r(cur[20]), .in21_r(cur[21]), .in22_r(cur[22]), .in23_r(cur[23]),
    .in24_r(cur[24]), .in25_r(cur[25]), .in26_r(cur[26]), .in27_r(cur[27]),
    .in28_r(cur[28]), .in29_r(cur[29]), .in30_r(cur[30]), .in31_r(cur[31]),
    .out0_r(o_r[0]),   .out1_r(o_r[1]),   .out2_r(o_r[2]),   .out3_r(o_r[3]),
    .out4_r(o_r[4]),   .out5_r(o_r[5]),   .out6_r(o_r[6]),   .out7_r(o_r[7]),
    .out8_r(o_r[8]),   .out9_r(o_r[9]),   .out10_r(o_r[10]), .out11_r(o_r[11]),
    .out12_r(o_r[12]), .out13_r(o_r[13]), .out14_r(o_r[14]), .out15_r(o_r[15]),
    .out16_r(o_r[16]), .out17_r(o_r[17]), .out18_r(o_r[18]), .out19_r(o_r[19]),
    .out20_r(o_r[20]), .out21_r(o_r[21]), .out22_r(o_r[22]), .out23_r(o_r[23]),
    .out24_r(o_r[24]), .out25_r(o_r[25]), .out26_r(o_r[26]), .out27_r(o_r[27]),
    .out28_r(o_r[28]), .out29_r(o_r[29]), .out30_r(o_r[30]), .out31_r(o_r[31]),
    .out0_i(o_i[0]),   .out1_i(o_i[1]),   .out2_i(o_i[2]),   .out3_i(o_i[3]),
    .out4_i(o_i[4]),   .out5_i(o_i[5]),   .out6_i(o_i[6]),   .out7_i(o_i[7]),
    .out8_i(o_i[8]),   .out9_i(o_i[9]),   .out10_i(o_i[10]), .out11_i(o_i[11]),
    .out12_i(o_i[12]), .out13_i(o_i[13]), .out14_i(o_i[14]), .out15_i(o_i[15]),
    .out16_i(o_i[16]), .out17_i(o_i[17]), .out18_i(o_i[18]), .out19_i(o_i[19]),
    .out20_i(o_i[20]), .out21_i(o_i[21]), .out22_i(o_i[22]), .out23_i(o_i[23]),
    .out24_i(o_i[24]), .out25_i(o_i[25]), .out26_i(o_i[26]), .out27_i(o_i[27]),
    .out28_i(o_i[28]), .out29_i(o_i[29]), .out30_i(o_i[30]), .out31_i(o_i[31])
  );

  function automatic int rnd(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int bitrev5(int n);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) if ((n & (1 << b)) != 0) r = r | (1 << (4 - b));
    return r;
  endfunction

  // Exact fixed-point transform: twiddles rounded from cos/sin, products floor-shifted, sums wrap
  function automatic void fft_model(input logic [31:0] x [32], output int yr [32], output int yi [32]);
    int     ar [32];
    int     ai [32];
    int     k, tr, ti;
    longint wr, wi, br, bi;
    for (int n = 0; n < 32; n++) begin
      ar[n] = int'(x[bitrev5(n)]);
      ai[n] = 0;
    end
    for (int h = 1; h < 32; h = h * 2) begin
      for (int j = 0; j < 32; j++) begin
        if ((j % (2 * h)) < h) begin
          k  = (j % h) * (16 / h);
          wr = longint'(rnd(16384.0 * $cos(2.0 * PI * k / 32.0)));
          wi = longint'(rnd(-16384.0 * $sin(2.0 * PI * k / 32.0)));
          br = longint'(ar[j+h]);
          bi = longint'(ai[j+h]);
          tr = int'((br * wr - bi * wi) >>> 14);
          ti = int'((br * wi + bi * wr) >>> 14);
          ar[j+h] = ar[j] - tr;
          ai[j+h] = ai[j] - ti;
          ar[j]   = ar[j] + tr;
          ai[j]   = ai[j] + ti;
        end
      end
    end
    yr = ar;
    yi = ai;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %h required %h", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp, input int tol);
    int d;
    d = int'(obs) - int'(exp);
    n_vec++;
    assert ((d >= -tol && d <= tol) === 1'b1) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %h required %h +/- %0d", tag, idx, obs, exp, tol);
    end
  endtask

  // One clock: advance the 6-deep expected-frame pipeline, then compare every bin
  task automatic step();
    int yr [32];
    int yi [32];
    @(posedge clk);
    if (!rst) begin
      for (int s = 0; s < 6; s++)
        for (int n = 0; n < 32; n++) begin
          p_r[s][n] = 0;
          p_i[s][n] = 0;
        end
    end else begin
      for (int s = 5; s > 0; s--) begin
        p_r[s] = p_r[s-1];
        p_i[s] = p_i[s-1];
      end
      fft_model(cur, yr, yi);
      p_r[0] = yr;
      p_i[0] = yi;
    end
    #1;
    for (int n = 0; n < 32; n++) begin
      chk("pipe_r", n, o_r[n], p_r[5][n]);
      chk("pipe_i", n, o_i[n], p_i[5][n]);
    end
  endtask

  task automatic rand_frame(input bit full);
    for (int n = 0; n < 32; n++)
      cur[n] = full ? 32'($urandom) : 32'($urandom_range(0, 32'h07FF_FFFF)) - 32'h0400_0000;
  endtask

  task automatic const_frame(input int kind);
    for (int n = 0; n < 32; n++)
      case (kind)
        0:       cur[n] = 32'h0;
        1:       cur[n] = (n == 0) ? 32'h0001_0000 : 32'h0;
        2:       cur[n] = 32'h0001_0000;
        3:       cur[n] = (n % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
        4:       cur[n] = (n == 1) ? 32'h0001_0000 : 32'h0;
        default: cur[n] = 32'(rnd(65536.0 * $cos(2.0 * PI * n / 32.0)));
      endcase
  endtask

  task automatic check_impulse(input string tag);
    for (int n = 0; n < 32; n++) begin
      chk({tag, "_r"}, n, o_r[n], 32'h0001_0000);
      chk({tag, "_i"}, n, o_i[n], 32'h0);
    end
  endtask

  task automatic check_dc();
    for (int n = 0; n < 32; n++) begin
      chk("dc_r", n, o_r[n], (n == 0) ? 32'h0020_0000 : 32'h0);
      chk("dc_i", n, o_i[n], 32'h0);
    end
  endtask

  task automatic run_directed(input int kind);
    const_frame(kind);
    step();
    const_frame(0);
    repeat (5) step();
  endtask

  initial begin
    rst = 1'b0;
    rand_frame(1'b1);
    step();
    for (int n = 0; n < 32; n++) begin
      chk("rst_r", n, o_r[n], 32'h0);
      chk("rst_i", n, o_i[n], 32'h0);
    end
    step();

    rst = 1'b1;
    run_directed(1);
    check_impulse("imp");
    run_directed(2);
    check_dc();
    run_directed(3);
    for (int n = 0; n < 32; n++) begin
      chk("nyq_r", n, o_r[n], (n == 16) ? 32'h0020_0000 : 32'h0);
      chk("nyq_i", n, o_i[n], 32'h0);
    end
    run_directed(4);
    chk("del0_r", 0, o_r[0], 32'h0001_0000);   chk("del0_i", 0, o_i[0], 32'h0);
    chk("del8_r", 8, o_r[8], 32'h0);           chk("del8_i", 8, o_i[8], 32'hFFFF_0000);
    chk("del16_r", 16, o_r[16], 32'hFFFF_0000); chk("del16_i", 16, o_i[16], 32'h0);
    chk("del24_r", 24, o_r[24], 32'h0);        chk("del24_i", 24, o_i[24], 32'h0001_0000);
    chk_tol("del4_r", 4, o_r[4], 32'h0000_B504, 1);
    chk_tol("del4_i", 4, o_i[4], 32'hFFFF_4AFC, 1);
    run_directed(5);
    for (int n = 0; n < 32; n++) begin
      chk_tol("cos_r", n, o_r[n], (n == 1 || n == 31) ? 32'h0010_0000 : 32'h0, 64);
      chk_tol("cos_i", n, o_i[n], 32'h0, 64);
    end

    const_frame(2);
    step();
    const_frame(1);
    step();
    repeat (4) begin
      rand_frame(1'b0);
      step();
    end
    check_dc();
    rand_frame(1'b0);
    step();
    check_impulse("stream_imp");

    for (int c = 0; c < 40; c++) begin
      rand_frame(c[0]);
      step();
    end

    rst = 1'b0;
    for (int n = 0; n < 32; n++) cur[n] = 'x;
    step();
    for (int n = 0; n < 32; n++) begin
      chk("midrst_r", n, o_r[n], 32'h0);
      chk("midrst_i", n, o_i[n], 32'h0);
    end
    rst = 1'b1;
    rand_frame(1'b0);
    step();
    repeat (12) begin
      rand_frame(1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
